reg_file_param: RTL and testbench
=================================

Name: reg_file_param

Overview:
- Parametrised register file for the single-cycle/pipelined CPU datapath: one write port, NUM_READ asynchronous read ports.
- Optional hardwired-zero register 0.
- Optional write-to-read bypass.
- Built-in post-reset clear sequencer that zeroes every entry, one per cycle, and flags busy while doing so.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- write_en, input, 1, write strobe, sampled at posedge clk.
- write_addr, input, ADDR_W, write address.
- write_data, input, DATA_W, write data.
- read_addr, input, NUM_READ*ADDR_W, packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- read_data, output, NUM_READ*DATA_W, packed read data; port i = bits [i*DATA_W +: DATA_W].
- init_busy, output, 1, high while the clear sequencer runs; writes are ignored while high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; there is no asynchronous reset.
- FSM states: CLEAR and READY.
  - rst=1 at a posedge: state <= CLEAR, clr_ptr <= 0. No entry is written in that cycle.
  - While rst stays high, the FSM stays in CLEAR with clr_ptr=0.
- CLEAR, rst=0, at each posedge:
  - mem[clr_ptr] <= 0.
  - clr_ptr <= clr_ptr+1.
  - When clr_ptr == DEPTH-1, state <= READY on that same edge.
  - The clear therefore takes exactly DEPTH cycles after rst deasserts.
- init_busy = (state == CLEAR). It reads 1 from the first posedge with rst=1 through the last clear edge. The power-up state before the first rst is don't-care.
- rst asserted mid-clear: the sequence restarts at clr_ptr=0 with the full DEPTH-cycle clear.
- READY write:
  - At posedge, if write_en=1 and not (ZERO_REG && write_addr==0): mem[write_addr] <= write_data.
  - Writes during CLEAR or with rst=1 are dropped silently, with no queuing.
- Read (combinational, every port independent):
  - ZERO_REG && addr==0 -> 0.
  - Else if state==CLEAR -> 0.
  - Else if BYPASS && write_en && addr==write_addr -> write_data.
  - Else -> mem[addr].
- With BYPASS=0, a read returns the old contents until the edge; the new value is visible the cycle after the write.
- Multiple read ports may use the same address; all return identical data.
- Width rules: there is no truncation or extension. Addresses are full-range, so out-of-range is impossible. clr_ptr is ADDR_W bits wide, and the DEPTH-1 compare uses ADDR_W bits.
- Latency: read is 0 cycles. Write is 1 cycle, or 0 cycles as seen through bypass.

Decomposition:
- Shared package reg_file_pkg holds:
  - rf_state_t enum {RF_CLEAR, RF_READY}.
  - Function rf_depth(addr_w) returning 2**addr_w.
  - Localparam RF_MAX_READ=4.
- Sub-module reg_file_clear_fsm holds the state, clr_ptr, init_busy and the clear write-enable/address. The top level muxes the clear write against the user write and generates the NUM_READ read muxes.

Test Plan:
- Reset clear: preload entry 7 with 0xDEADBEEF, pulse rst for 1 cycle (defaults) -> init_busy=1 for exactly 32 cycles after rst falls, then 0; read entry 7 = 0x00000000.
- Reset mid-clear: assert rst at clear cycle 10 for 2 cycles -> init_busy stays 1 for 32 more cycles after the second deassert; all entries read 0.
- Write/read with bypass: READY, write_en=1, write_addr=5, write_data=0x12345678, read_addr port0=5 in the same cycle -> read_data port0=0x12345678 combinationally; next cycle with write_en=0 still 0x12345678. With BYPASS=0, the same cycle shows 0, the next cycle 0x12345678.
- Zero register: write 0xFFFFFFFF to addr 0 -> reads on all ports at addr 0 return 0. With ZERO_REG=0, the next cycle returns 0xFFFFFFFF.
- Writes during clear dropped: during CLEAR write 0xA5A5A5A5 to addr 31 -> after READY, addr 31 reads 0.
- Parametrised instance DATA_W=16, ADDR_W=3, NUM_READ=4: write 0xBEEF to addr 6, all four ports read addr 6 -> each returns 0xBEEF; clear takes 8 cycles.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear-sequencer state encoding and depth derivation.
package reg_file_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

    localparam int RF_MAX_READ = 4;

    function automatic int rf_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, issuing a zero write
// per cycle, and reports busy until the last entry has been cleared.
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_t         state;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            clr_ptr <= '0;
        end else if (state == RF_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == {ADDR_W{1'b1}}) begin
                state <= RF_READY;
            end
        end
    end

    // The clear write is suppressed on a reset edge so no entry is touched then.
    assign init_busy = (state == RF_CLEAR);
    assign clr_we    = init_busy && !rst;
    assign clr_addr  = clr_ptr;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, NUM_READ combinational read
// ports, optional hardwired-zero entry 0 and optional write-to-read bypass.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_en,
    input  logic [ADDR_W-1:0]            write_addr,
    input  logic [DATA_W-1:0]            write_data,
    input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
    output logic [NUM_READ*DATA_W-1:0]   read_data,
    output logic                         init_busy
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    reg_file_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // User writes are dropped outright while clearing or in reset.
    assign user_we = write_en && !init_busy && !rst &&
                     !((ZERO_REG != 0) && (write_addr == '0));

    assign wr_en   = clr_we || user_we;
    assign wr_addr = clr_we ? clr_addr : write_addr;
    assign wr_data = clr_we ? '0 : write_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = read_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end else if (init_busy) begin
                rd = '0;
            end else if ((BYPASS != 0) && write_en && (ra == write_addr)) begin
                rd = write_data;
            end
        end

        assign read_data[i*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: four instances (default, no bypass, no zero
// register, narrow 4-port) checked against a behavioural model every cycle.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [2:0]  wa3;
    logic [15:0] wd3;
    logic [11:0] ra3;

    logic [63:0] rd0, rd1, rd2, rd3;
    logic        busy0, busy1, busy2, busy3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
        .read_addr(ra), .read_data(rd0), .init_busy(busy0));
    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
        .read_addr(ra), .read_data(rd1), .init_busy(busy1));
    reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(1)) u2 (
        .clk(clk), .rst(rst), .write_en(we), .write_addr(wa), .write_data(wd),
        .read_addr(ra), .read_data(rd2), .init_busy(busy2));
    reg_file_param #(.DATA_W(16), .ADDR_W(3), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)) u3 (
        .clk(clk), .rst(rst), .write_en(we), .write_addr(wa3), .write_data(wd3),
        .read_addr(ra3), .read_data(rd3), .init_busy(busy3));

    // ---------------- behavioural model ----------------
    logic [31:0] mm [4][32];
    int          clr_left [4];
    bit          model_ok = 1'b0;

    function automatic bit   byp(int k);   return k != 1;          endfunction
    function automatic bit   zr(int k);    return k != 2;          endfunction
    function automatic int   depth(int k); return (k == 3) ? 8 : 32; endfunction
    function automatic int   nrd(int k);   return (k == 3) ? 4 : 2;  endfunction
    function automatic int   wak(int k);   return (k == 3) ? int'(wa3) : int'(wa); endfunction
    function automatic logic [31:0] wdk(int k);
        return (k == 3) ? {16'h0, wd3} : wd;
    endfunction
    function automatic int rak(int k, int p);
        return (k == 3) ? int'(ra3[p*3 +: 3]) : int'(ra[p*5 +: 5]);
    endfunction
    function automatic logic [31:0] act_rd(int k, int p);
        case (k)
            0:       return rd0[p*32 +: 32];
            1:       return rd1[p*32 +: 32];
            2:       return rd2[p*32 +: 32];
            default: return {16'h0, rd3[p*16 +: 16]};
        endcase
    endfunction
    function automatic logic act_busy(int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            2:       return busy2;
            default: return busy3;
        endcase
    endfunction
    function automatic logic [31:0] exp_rd(int k, int p);
        int a;
        a = rak(k, p);
        if (zr(k) && a == 0)                  return 32'h0;
        if (clr_left[k] > 0)                  return 32'h0;
        if (byp(k) && we && a == wak(k))      return wdk(k);
        return mm[k][a];
    endfunction

    // Clearing is modelled as: reads return 0 for DEPTH cycles, then all entries are 0.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                clr_left[k] <= depth(k);
            end else if (clr_left[k] > 0) begin
                clr_left[k] <= clr_left[k] - 1;
                if (clr_left[k] == 1)
                    for (int a = 0; a < 32; a++) mm[k][a] <= 32'h0;
            end else if (we && !(zr(k) && wak(k) == 0)) begin
                mm[k][wak(k)] <= wdk(k);
            end
        end
        if (rst) model_ok <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("u%0d_busy", k), {31'h0, act_busy(k)},
                    {31'h0, (clr_left[k] > 0)});
                for (int p = 0; p < nrd(k); p++)
                    chk($sformatf("u%0d_rd%0d_a%0d", k, p, rak(k, p)), act_rd(k, p), exp_rd(k, p));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int c0, output int c3);
        c0 = 0;
        c3 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy0) c0++;
            if (busy3) c3++;
            if (!busy0 && !busy3) break;
        end
    endtask

    initial begin
        int c0, c3;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
        wa3 = '0; wd3 = '0; ra3 = '0;
        step(); step();
        rst = 1'b0;
        count_busy(c0, c3);
        chk("init_clear_len_u0", c0, 32);
        chk("init_clear_len_u3", c3, 8);

        // Preload entry 7, then reset and confirm it is cleared.
        step(); we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; wa3 = 3'd7; wd3 = 16'hDEAD;
        step(); we = 1'b0; ra = {5'd7, 5'd7}; ra3 = {4{3'd7}};
        @(negedge clk);
        chk("preload_e7", rd0[31:0], 32'hDEADBEEF);
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        count_busy(c0, c3);
        chk("clear_len_u0", c0, 32);
        chk("clear_len_u3", c3, 8);
        chk("e7_cleared_u0", rd0[31:0], 32'h0);
        chk("e7_cleared_u3", {16'h0, rd3[31:16]}, 32'h0);

        // Reset again part way through a clear.
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        count_busy(c0, c3);
        chk("midclear_len_u0", c0, 32);
        for (int a = 0; a < 32; a++) begin
            step(); ra = {5'(31 - a), 5'(a)}; ra3 = {4{3'(a)}};
        end

        // Same-cycle bypass versus next-cycle visibility.
        step(); we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra = {5'd0, 5'd5};
        @(negedge clk);
        chk("bypass_same_u0", rd0[31:0], 32'h12345678);
        chk("nobypass_same_u1", rd1[31:0], 32'h0);
        step(); we = 1'b0;
        @(negedge clk);
        chk("bypass_next_u0", rd0[31:0], 32'h12345678);
        chk("nobypass_next_u1", rd1[31:0], 32'h12345678);

        // Hardwired zero register.
        step(); we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = {5'd0, 5'd0};
        @(negedge clk);
        chk("zero_same_p0", rd0[31:0], 32'h0);
        chk("zero_same_p1", rd0[63:32], 32'h0);
        chk("nozero_same_byp", rd2[31:0], 32'hFFFFFFFF);
        step(); we = 1'b0;
        @(negedge clk);
        chk("zero_next_p1", rd0[63:32], 32'h0);
        chk("nozero_next", rd2[63:32], 32'hFFFFFFFF);

        // Writes during clear are dropped.
        step(); rst = 1'b1;
        step(); rst = 1'b0; we = 1'b1; wa = 5'd31; wd = 32'hA5A5A5A5; ra = {5'd31, 5'd3};
        repeat (20) step();
        we = 1'b0;
        count_busy(c0, c3);
        step(); ra = {5'd31, 5'd31};
        @(negedge clk);
        chk("clear_write_dropped", rd0[63:32], 32'h0);

        // Narrow four-port instance.
        step(); we = 1'b1; wa = 5'd9; wd = 32'h1; wa3 = 3'd6; wd3 = 16'hBEEF;
        step(); we = 1'b0; ra3 = {4{3'd6}};
        @(negedge clk);
        for (int p = 0; p < 4; p++)
            chk($sformatf("u3_port%0d_e6", p), {16'h0, rd3[p*16 +: 16]}, 32'h0000BEEF);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            we  = $urandom_range(0, 1) == 1;
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            wa3 = 3'($urandom_range(0, 7));
            wd3 = 16'($urandom);
            for (int p = 0; p < 2; p++)
                ra[p*5 +: 5] = ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++)
                ra3[p*3 +: 3] = ($urandom_range(0, 1) == 1) ? wa3 : 3'($urandom_range(0, 7));
        end
        step(); rst = 1'b0; we = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
